// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing one line-wide memory interface between icache (port 0) and dcache (port 1).
// Latency: mem_enable_o rises one cycle after a request is sampled in IDLE; the ack pulse comes one cycle after mem_ack_i.
// Backpressure: one transaction at a time; losing/late requesters hold req until their ack, and memory stalls by delaying mem_ack_i.
module dmem_arbiter #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              p0_req_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,

    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,

    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              gnt;        // port owning the current transaction
    logic              last_gnt;   // port granted most recently, loses the next tie
    logic              win;        // arbitration winner among current requesters
    logic              grant;      // a new transaction is accepted on this edge
    logic              finish;     // memory completes the current transaction on this edge
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state, round-robin winner and the selected requester's fields
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        finish    = 1'b0;
        // a tie goes to the port that was not served last; otherwise the lone requester wins
        if (p0_req_i && p1_req_i) begin
            win = ~last_gnt;
        end else begin
            win = p1_req_i;
        end
        sel_write = win ? p1_write_i : p0_write_i;
        sel_addr  = win ? p1_addr_i  : p0_addr_i;
        sel_data  = win ? p1_data_i  : p0_data_i;
        case (state)
            IDLE: begin
                if (p0_req_i || p1_req_i) begin
                    grant     = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack_i) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // one cycle for the ack pulse; the requester drops req meanwhile so it is not re-granted
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // latch the winner's request; the memory address/data outputs are the latches themselves
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            gnt        <= 1'b0;
            last_gnt   <= 1'b1;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else if (grant) begin
            gnt        <= win;
            last_gnt   <= win;
            mem_addr_o <= sel_addr;
            mem_data_o <= sel_data;
        end
    end

    // registered memory strobes, busy flag and the one-cycle requester acks
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            busy_o       <= 1'b0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
        end else begin
            mem_enable_o <= (state_nxt == BUSY);
            busy_o       <= (state_nxt != IDLE);
            p0_ack_o     <= finish && !gnt;
            p1_ack_o     <= finish && gnt;
            if (grant) begin
                mem_write_o <= sel_write;
            end else if (finish) begin
                mem_write_o <= 1'b0;
            end
        end
    end

    // read data returns only to the owner of a completed read; writes leave it alone
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            p0_data_o <= '0;
            p1_data_o <= '0;
        end else if (finish && !mem_write_o) begin
            if (gnt) begin
                p1_data_o <= mem_data_i;
            end else begin
                p0_data_o <= mem_data_i;
            end
        end
    end

endmodule
